instr_load_ctrl: RTL and testbench

- Program-load controller in front of the pipelined CPU's instruction memory.
- Accepts a byte-serial program stream and packs it little-endian into 32-bit words.
- Writes each word into instruction memory at sequential word addresses.
- Holds the CPU in reset for the whole load, then releases it after a programmable settle delay.

---
 rtl/instr_load_ctrl.sv | 140 ++++++++++++++
 tb/tb_instr_load_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_load_ctrl.sv
// Program-load controller: packs a byte stream little-endian into 32-bit words,
// writes them to instruction memory and holds the CPU in reset until settled.

module instr_load_lane (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)   q <= '0;
    else if (we) q <= d;
endmodule

module instr_load_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_start_i,
  input  logic              load_done_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              imem_wr_en_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wr_data_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o
);
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = $clog2(RELEASE_CYCLES + 1);
  localparam logic [ADDR_W:0]  MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] REL_INIT  = CNT_W'(RELEASE_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, ERROR} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                lane_q, lane_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [ADDR_W:0]           count_d;
  logic                      wr_en_d;
  logic [ADDR_W-1:0]         wr_addr_d;
  logic [31:0]               wr_data_d;
  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] pack, word;

  // The completing byte bypasses its lane register so the word can be written
  // on the very next cycle.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    instr_load_lane u_lane (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we    (lane_we[g]),
      .d     (byte_i),
      .q     (pack[g])
    );
    assign word[g] = (lane_q == 2'(g)) ? byte_i : pack[g];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    addr_d    = addr_q;
    count_d   = word_count_o;
    wr_en_d   = 1'b0;
    wr_addr_d = imem_addr_o;
    wr_data_d = imem_wr_data_o;
    lane_we   = '0;
    if (load_start_i) begin
      state_d = LOAD;
      lane_d  = '0;
      addr_d  = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        RELEASE: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
        LOAD: begin
          if (byte_valid_i && word_count_o == MAX_WORDS) begin
            state_d = ERROR;
          end else begin
            if (byte_valid_i) begin
              lane_we[lane_q] = 1'b1;
              lane_d          = lane_q + 1'b1;
              if (lane_q == 2'd3) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = word;
                addr_d    = addr_q + 1'b1;
                count_d   = word_count_o + 1'b1;
              end
            end
            // Lane check sees the byte accepted in this same cycle.
            if (load_done_i) begin
              state_d = (lane_d == 2'd0) ? RELEASE : ERROR;
              cnt_d   = REL_INIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= RELEASE;
      cnt_q          <= REL_INIT;
      lane_q         <= '0;
      addr_q         <= '0;
      imem_wr_en_o   <= 1'b0;
      imem_addr_o    <= '0;
      imem_wr_data_o <= '0;
      word_count_o   <= '0;
      cpu_rst_o      <= 1'b1;
      busy_o         <= 1'b1;
      err_o          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lane_q         <= lane_d;
      addr_q         <= addr_d;
      imem_wr_en_o   <= wr_en_d;
      imem_addr_o    <= wr_addr_d;
      imem_wr_data_o <= wr_data_d;
      word_count_o   <= count_d;
      cpu_rst_o      <= (state_d != IDLE);
      busy_o         <= (state_d != IDLE);
      err_o          <= (state_d == ERROR);
    end
  end
endmodule

// File: tb/tb_instr_load_ctrl.sv
// Scoreboard bench for instr_load_ctrl: a byte-stream model predicts writes,
// a negedge monitor checks every strobe and the hold behaviour between them.

module tb_instr_load_ctrl;
  localparam int ADDR_W = 2;
  localparam int REL    = 4;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0, load_done = 1'b0, byte_valid = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wr_data;
  logic              cpu_rst, busy, err;
  logic [ADDR_W:0]   word_count;

  always #5 clk = ~clk;

  instr_load_ctrl #(.ADDR_W(ADDR_W), .RELEASE_CYCLES(REL)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_start_i   (load_start),
    .load_done_i    (load_done),
    .byte_valid_i   (byte_valid),
    .byte_i         (byte_in),
    .imem_wr_en_o   (imem_wr_en),
    .imem_addr_o    (imem_addr),
    .imem_wr_data_o (imem_wr_data),
    .cpu_rst_o      (cpu_rst),
    .busy_o         (busy),
    .err_o          (err),
    .word_count_o   (word_count)
  );

  typedef struct { int addr; logic [31:0] data; int cnt; } wr_t;
  wr_t exp_q[$];
  int  n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard; between
  // strobes the address/data outputs must hold.
  logic [ADDR_W-1:0] last_addr = '0;
  logic [31:0]       last_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      last_addr <= '0;
      last_data <= '0;
    end else if (imem_wr_en) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                 imem_addr, imem_wr_data);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(w.addr));
        chk("wr_data", imem_wr_data, w.data);
        chk("wr_count", 32'(word_count), 32'(w.cnt));
      end
      last_addr <= imem_addr;
      last_data <= imem_wr_data;
    end else begin
      chk("hold_addr", 32'(imem_addr), 32'(last_addr));
      chk("hold_data", imem_wr_data, last_data);
    end
  end

  // Reference model of one load: bytes accumulate little-endian, every fourth
  // completes a word at the next sequential address, capacity overrun is an error.
  int         m_words, m_lane;
  logic [31:0] m_w;
  bit         m_err;
  bit         in_err = 1'b0;
  logic [7:0] stim_q[$];

  task automatic model_start();
    m_words = 0; m_lane = 0; m_w = '0; m_err = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] b);
    if (m_err) return;
    if (m_words == CAP) begin
      m_err = 1'b1;
      return;
    end
    m_w = m_w | (32'(b) << (8 * m_lane));
    m_lane++;
    if (m_lane == 4) begin
      exp_q.push_back('{addr: m_words % CAP, data: m_w, cnt: m_words + 1});
      m_words++;
      m_lane = 0;
      m_w    = '0;
    end
  endtask

  task automatic feed_done();
    if (!m_err && m_lane != 0) m_err = 1'b1;
  endtask

  task automatic drive(input logic st, input logic bv, input logic [7:0] b, input logic dn);
    load_start = st; byte_valid = bv; byte_in = b; load_done = dn;
    @(negedge clk);
    load_start = 1'b0; byte_valid = 1'b0; load_done = 1'b0;
  endtask

  task automatic chk_release();
    for (int k = 0; k <= REL; k++) begin
      chk("cpu_rst_release", 32'(cpu_rst), 32'(k < REL));
      chk("busy_release", 32'(busy), 32'(k < REL));
      if (k < REL) @(negedge clk);
    end
  endtask

  task automatic run_load(input bit done_same, input bit gaps, input int junk);
    bit last;
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      chk("parked_cpu_rst", 32'(cpu_rst), 32'(in_err));
      chk("parked_err", 32'(err), 32'(in_err));
    end
    if (junk > 0) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      model_start();
      for (int j = 0; j < junk; j++) begin
        b = 8'($urandom);
        feed_byte(b);
        drive(1'b0, 1'b1, b, 1'b0);
      end
    end
    drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    model_start();
    chk("start_count", 32'(word_count), 32'd0);
    chk("start_err", 32'(err), 32'd0);
    chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < stim_q.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 8'($urandom), 1'b0);
      last = (i == stim_q.size() - 1);
      feed_byte(stim_q[i]);
      if (last && done_same) feed_done();
      drive(1'b0, 1'b1, stim_q[i], last && done_same);
    end
    if (!(done_same && stim_q.size() > 0)) begin
      feed_done();
      drive(1'b0, 1'b0, 8'h00, 1'b1);
    end
    if (m_err) begin
      repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);
      chk("err_set", 32'(err), 32'd1);
      chk("err_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("err_busy", 32'(busy), 32'd1);
    end else begin
      chk_release();
      chk("ok_err", 32'(err), 32'd0);
    end
    chk("final_count", 32'(word_count), 32'(m_words));
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    in_err = m_err;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, then the settle delay after reset release.
    repeat (3) @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_wr_en", 32'(imem_wr_en), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_data", imem_wr_data, 32'd0);
    rst = 1'b0;
    chk_release();

    // Two-word program.
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(1'b0, 1'b0, 0);

    // Partial word ends in ERROR; the next load's start clears it.
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_load(1'b0, 1'b0, 0);

    // Last byte and done in the same cycle.
    stim_q = '{8'hde, 8'had, 8'hbe, 8'hef};
    run_load(1'b1, 1'b0, 0);

    // Overflow: 17 bytes into a 4-word memory.
    stim_q.delete();
    for (int i = 0; i < 17; i++) stim_q.push_back(8'(i + 1));
    run_load(1'b0, 1'b0, 0);

    // Restart mid-load with a word already written.
    stim_q = '{8'ha1, 8'hb2, 8'hc3, 8'hd4};
    run_load(1'b0, 1'b0, 5);

    // Reset in the middle of a load.
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    model_start();
    drive(1'b0, 1'b1, 8'h5a, 1'b0);
    drive(1'b0, 1'b1, 8'ha5, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("async_busy", 32'(busy), 32'd1);
    chk("async_wr_en", 32'(imem_wr_en), 32'd0);
    chk("async_count", 32'(word_count), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_start();
    chk_release();
    in_err = 1'b0;
    chk("rst_pending", 32'(exp_q.size()), 32'd0);

    // Randomized loads.
    for (int t = 0; t < 40; t++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 18) : 4 * $urandom_range(0, 4);
      stim_q.delete();
      for (int i = 0; i < len; i++) stim_q.push_back(8'($urandom));
      run_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
